// File: rtl/bitplane_serializer.sv
// ---------------------------------------------------------------------------
// bitplane_serializer
//   On a start pulse, reads NUM_WORDS words from the single-port RB memory
//   into a local buffer, then sends WORD_W serial packets on sd/sen. Packet k
//   carries bit plane WORD_W-1-k: the PKT_AW-bit index k (MSB first), then
//   bit p of words NUM_WORDS-1 down to 0. Packets are separated by one idle
//   cycle.
//
//   Optional feature macro: PKT_PARITY_EN
//     When defined, each packet ends with one even-parity bit computed over
//     its index and data bits.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active high
//   start  in   1-cycle frame request, ignored unless idle
//   busy   out  high from the cycle after an accepted start until done
//   done   out  1-cycle pulse after the last packet bit
//   RB_RW  out  memory read/write select, constant 1 (read)
//   RB_A   out  memory address
//   RB_D   out  memory write data, constant 0
//   RB_Q   in   memory read data, valid 1 cycle after RB_A
//   sen    out  serial enable, active low while a packet bit is on sd
//   sd     out  serial data
// ---------------------------------------------------------------------------
module bitplane_serializer #(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned NUM_WORDS = 18,
   parameter int unsigned RB_AW     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              RB_RW,
   output logic [RB_AW-1:0]  RB_A,
   output logic [WORD_W-1:0] RB_D,
   input  logic [WORD_W-1:0] RB_Q,
   output logic              sen,
   output logic              sd
);

   localparam int unsigned PKT_AW = $clog2(WORD_W);
   localparam int unsigned PW     = PKT_AW + 1;
   // One counter serves the load phase (0..NUM_WORDS), the index field and the data bits.
   localparam int unsigned CW     = $clog2(NUM_WORDS + WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ADDR, S_DATA, S_PAR, S_GAP, S_FIN
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [PW-1:0]     pkt, pkt_n;
   logic [RB_AW-1:0]  rb_a_n;
   logic              sen_n, sd_n, busy_n, done_n;
   logic              pkt_end;
   logic              addr_bit, data_bit;
   logic [WORD_W-1:0] word_sel;
   logic [WORD_W-1:0] wbuf [NUM_WORDS];
`ifdef PKT_PARITY_EN
   logic              par, par_n;
`endif

   assign RB_RW = 1'b1;
   assign RB_D  = '0;

   // Next state and counters
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pkt_n   = pkt;
      rb_a_n  = RB_A;
      pkt_end = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_LOAD;
               cnt_n   = '0;
               rb_a_n  = '0;
            end
         end
         S_LOAD: begin
            if (cnt == CW'(NUM_WORDS)) begin
               state_n = S_ADDR;
               cnt_n   = CW'(PKT_AW - 1);
               pkt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               if (cnt < CW'(NUM_WORDS - 1))
                  rb_a_n = RB_A + 1'b1;
            end
         end
         S_ADDR: begin
            if (cnt == '0) begin
               state_n = S_DATA;
               cnt_n   = CW'(NUM_WORDS - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
`ifdef PKT_PARITY_EN
               state_n = S_PAR;
`else
               pkt_end = 1'b1;
`endif
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`ifdef PKT_PARITY_EN
         S_PAR: pkt_end = 1'b1;
`endif
         S_GAP: begin
            state_n = S_ADDR;
            pkt_n   = pkt + 1'b1;
            cnt_n   = CW'(PKT_AW - 1);
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (pkt_end)
         state_n = (pkt == PW'(WORD_W - 1)) ? S_FIN : S_GAP;
   end

   // Output values for the next cycle, decoded from the next state so that
   // every output can be registered without an extra cycle of latency.
   always_comb begin
      addr_bit = 1'b0;
      for (int unsigned i = 0; i < PKT_AW; i++)
         if (cnt_n == CW'(i)) addr_bit = pkt_n[i];
      word_sel = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++)
         if (cnt_n == CW'(i)) word_sel = wbuf[i];
      // Plane WORD_W-1-k equals ~k because WORD_W is a power of two.
      data_bit = word_sel[~pkt_n[PKT_AW-1:0]];

      sen_n  = 1'b1;
      sd_n   = 1'b0;
      busy_n = (state_n != S_IDLE) && (state_n != S_FIN);
      done_n = (state_n == S_FIN);
      case (state_n)
         S_ADDR: begin sen_n = 1'b0; sd_n = addr_bit; end
         S_DATA: begin sen_n = 1'b0; sd_n = data_bit; end
`ifdef PKT_PARITY_EN
         S_PAR:  begin sen_n = 1'b0; sd_n = par;      end
`endif
         default: ;
      endcase
`ifdef PKT_PARITY_EN
      if (state_n == S_ADDR || state_n == S_DATA)
         par_n = par ^ sd_n;
      else if (state_n == S_PAR)
         par_n = par;
      else
         par_n = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         pkt   <= '0;
         RB_A  <= '0;
         sen   <= 1'b1;
         sd    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef PKT_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pkt   <= pkt_n;
         RB_A  <= rb_a_n;
         sen   <= sen_n;
         sd    <= sd_n;
         busy  <= busy_n;
         done  <= done_n;
`ifdef PKT_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   // In load cycle c (c >= 1) RB_Q holds the word addressed in cycle c-1.
   always_ff @(posedge clk) begin
      if (state == S_LOAD) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++)
            if (cnt == CW'(i + 1)) wbuf[i] <= RB_Q;
      end
   end

endmodule
